// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack memory port and holds the word for the decoder.
// Optional macro FETCH_TIMEOUT_EN adds a MAX_WAIT-cycle fetch timeout with a sticky error flag.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pc_enable_in,
    input  logic        stall_in,
    output logic [31:0] imem_addr_out,
    output logic        imem_req_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  func_out,
    output logic        instr_valid_out,
    output logic [31:0] pc_out,
    output logic        fetch_err_out
);

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t state;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("instr_fetch: MAX_WAIT must be in 1..255");
    end

    assign opcode_out = instr_out[31:26];
    assign func_out   = instr_out[5:0];

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    logic [7:0] wait_cnt;
    logic       timeout;
    assign timeout = (wait_cnt == WAIT_LAST);
`else
    assign fetch_err_out = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            pc_out          <= START_PC;
            imem_addr_out   <= START_PC;
            imem_req_out    <= 1'b0;
            instr_out       <= 32'h0;
            instr_valid_out <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err_out   <= 1'b0;
            wait_cnt        <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    imem_req_out  <= 1'b1;
                    imem_addr_out <= pc_out;
                    state         <= FETCH;
                end
                // An outstanding fetch always completes; stall/pc_enable are not looked at here.
                FETCH: begin
                    if (imem_ack_in) begin
                        instr_out       <= imem_data_in;
                        instr_valid_out <= 1'b1;
                        imem_req_out    <= 1'b0;
                        state           <= HOLD;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt        <= 8'd0;
                    end else if (timeout) begin
                        // Substitute a NOP so execution carries on past the dead address.
                        instr_out       <= 32'h0;
                        instr_valid_out <= 1'b1;
                        imem_req_out    <= 1'b0;
                        fetch_err_out   <= 1'b1;
                        wait_cnt        <= 8'd0;
                        state           <= HOLD;
                    end else begin
                        wait_cnt        <= wait_cnt + 8'd1;
`endif
                    end
                end
                HOLD: begin
                    if (pc_enable_in && !stall_in) begin
                        pc_out          <= pc_out + 32'd4;
                        imem_addr_out   <= pc_out + 32'd4;
                        imem_req_out    <= 1'b1;
                        instr_valid_out <= 1'b0;
                        state           <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
